// File: rtl/ones_count_pkg.sv
// rtl/ones_count_pkg.sv - shared state encoding, mode constants and clog2 helper for the serial bit counter
package ones_count_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic MODE_ONES  = 1'b0;
    localparam logic MODE_ZEROS = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ones_count_chunk.sv
// rtl/ones_count_chunk.sv - combinational popcount of one masked, optionally inverted lane
module ones_count_chunk
    import ones_count_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]      lane,
    input  logic                  mode,
    input  logic [CHUNK-1:0]      lane_mask,
    output logic [clog2(CHUNK):0] ones
);

    localparam int PW = clog2(CHUNK) + 1;

    logic [CHUNK-1:0] bits;

    // Mask after inversion so padding lanes never count as zeros.
    assign bits = (lane ^ {CHUNK{mode}}) & lane_mask;

    always_comb begin
        ones = '0;
        for (int i = 0; i < CHUNK; i++) begin
            ones = ones + PW'(bits[i]);
        end
    end

endmodule

// File: rtl/ones_count_serial.sv
// rtl/ones_count_serial.sv - multi-cycle ones/zeros counter, CHUNK bits per clock, valid/ready on both sides
module ones_count_serial
    import ones_count_pkg::*;
#(
    parameter  int IN_WIDTH = 32,
    parameter  int CHUNK    = 8,
    localparam int CNT_W    = clog2(IN_WIDTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_vec,
    input  logic                mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_W-1:0]    count,
    output logic                busy
);

    localparam int NCHUNK     = (IN_WIDTH + CHUNK - 1) / CHUNK;
    localparam int SH_W       = NCHUNK * CHUNK;
    localparam int IDX_W      = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
    localparam int PW         = clog2(CHUNK) + 1;
    localparam int LAST_LANES = IN_WIDTH - (NCHUNK - 1) * CHUNK;
    localparam logic [CHUNK-1:0] LAST_MASK = {CHUNK{1'b1}} >> (CHUNK - LAST_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [SH_W-1:0]  sh;
    logic             mode_r;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_next;
    logic [CHUNK-1:0] lane_mask;
    logic [PW-1:0]    lane_ones;
    logic             last_chunk;

    assign last_chunk = (idx == LAST_IDX);
    assign lane_mask  = last_chunk ? LAST_MASK : {CHUNK{1'b1}};
    assign acc_next   = acc + CNT_W'(lane_ones);

    ones_count_chunk #(.CHUNK(CHUNK)) u_chunk (
        .lane      (sh[CHUNK-1:0]),
        .mode      (mode_r),
        .lane_mask (lane_mask),
        .ones      (lane_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
            busy      <= 1'b0;
            sh        <= '0;
            mode_r    <= MODE_ONES;
            idx       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        sh       <= SH_W'(in_vec);
                        mode_r   <= mode;
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    acc <= acc_next;
                    sh  <= sh >> CHUNK;
                    idx <= idx + 1'b1;
                    if (last_chunk) begin
                        count     <= acc_next;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // count stays loaded after the handshake until the next result.
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
